// File: rtl/sdram_port_arbiter_if.sv
// Port-side and controller-side bundle of the SDRAM port arbiter.
// slave = arbiter view, master = ports/controller view.
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [32*NUM_PORTS-1:0] port_adr_i;
  logic [16*NUM_PORTS-1:0] port_dat_i;
  logic [2*NUM_PORTS-1:0]  port_sel_i;
  logic [NUM_PORTS-1:0]    port_acc_i;
  logic [NUM_PORTS-1:0]    port_we_i;
  logic [NUM_PORTS-1:0]    port_ack_o;
  logic [31:0]             port_adr_o;
  logic [15:0]             port_dat_o;
  logic [NUM_PORTS-1:0]    grant_o;
  logic [31:0]             ctrl_adr_o;
  logic [15:0]             ctrl_dat_o;
  logic [1:0]              ctrl_sel_o;
  logic                    ctrl_acc_o;
  logic                    ctrl_we_o;
  logic                    ctrl_ack_i;
  logic [31:0]             ctrl_adr_i;
  logic [15:0]             ctrl_dat_i;

  modport slave (
    input  port_adr_i, port_dat_i, port_sel_i,
    input  port_acc_i, port_we_i,
    input  ctrl_ack_i, ctrl_adr_i, ctrl_dat_i,
    output port_ack_o, port_adr_o, port_dat_o,
    output grant_o,
    output ctrl_adr_o, ctrl_dat_o, ctrl_sel_o,
    output ctrl_acc_o, ctrl_we_o
  );

  modport master (
    output port_adr_i, port_dat_i, port_sel_i,
    output port_acc_i, port_we_i,
    output ctrl_ack_i, ctrl_adr_i, ctrl_dat_i,
    input  port_ack_o, port_adr_o, port_dat_o,
    input  grant_o,
    input  ctrl_adr_o, ctrl_dat_o, ctrl_sel_o,
    input  ctrl_acc_o, ctrl_we_o
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter of N SDRAM ports onto one controller.
// Read owners keep the grant briefly across burst gaps.
module sdram_port_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_rst,
  sdram_port_arbiter_if.slave   bus
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic          owner_we_q, owner_we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] pick;
  logic          req_any;
  logic          own_acc;
  logic          active;

  assign own_acc = bus.port_acc_i[owner_q];
  assign active  = (state_q != IDLE);

  // First requester after last, walking round the ring.
  always_comb begin
    pick    = '0;
    req_any = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (bus.port_acc_i[(int'(last_q) + k) % NUM_PORTS]) begin
        pick    = IW'((int'(last_q) + k) % NUM_PORTS);
        req_any = 1'b1;
      end
    end
  end

  // Next-state: grant, release, and read hold window.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    owner_we_d = owner_we_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          owner_d    = pick;
          owner_we_d = bus.port_we_i[pick];
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!own_acc) begin
          if (owner_we_q || HOLD_CYCLES == 0) begin
            state_d = IDLE;
            last_d  = owner_q;
          end else begin
            state_d = HOLD;
            cnt_d   = CW'(HOLD_CYCLES - 1);
          end
        end
      end
      HOLD: begin
        if (own_acc) begin
          state_d = GRANT;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and ownership registers.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= IW'(NUM_PORTS - 1);
      owner_we_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      owner_we_q <= owner_we_d;
      cnt_q      <= cnt_d;
    end
  end

  // Unregistered owner mux; ports react to ack in the same cycle.
  always_comb begin
    bus.ctrl_adr_o = '0;
    bus.ctrl_dat_o = '0;
    bus.ctrl_sel_o = '0;
    bus.ctrl_we_o  = 1'b0;
    bus.ctrl_acc_o = 1'b0;
    bus.grant_o    = '0;
    bus.port_ack_o = '0;
    if (active) begin
      bus.ctrl_adr_o = bus.port_adr_i[32*int'(owner_q) +: 32];
      bus.ctrl_dat_o = bus.port_dat_i[16*int'(owner_q) +: 16];
      bus.ctrl_sel_o = bus.port_sel_i[2*int'(owner_q) +: 2];
      bus.ctrl_we_o  = bus.port_we_i[owner_q];
      bus.ctrl_acc_o = own_acc;
      bus.grant_o[owner_q]    = 1'b1;
      bus.port_ack_o[owner_q] = bus.ctrl_ack_i;
    end
  end

  assign bus.port_adr_o = bus.ctrl_adr_i;
  assign bus.port_dat_o = bus.ctrl_dat_i;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus
// random traffic against a cycle-level reference model.
module tb_sdram_port_arbiter;
  localparam int NP = 2;
  localparam int HC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.NUM_PORTS(NP)) bus ();

  sdram_port_arbiter #(
    .NUM_PORTS  (NP),
    .HOLD_CYCLES(HC)
  ) dut (
    .sdram_clk(clk),
    .sdram_rst(rst),
    .bus      (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: owner -1 means nobody owns the controller,
  // m_hold counts remaining keep-alive cycles of a read owner.
  int m_owner = -1;
  int m_last  = NP - 1;
  int m_hold  = 0;
  bit m_we    = 1'b0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [NP-1:0] g, a;
    logic [31:0]   ea;
    logic [15:0]   ed;
    logic [1:0]    es;
    logic          eacc, ewe;
    g = '0; a = '0; ea = '0; ed = '0; es = '0;
    eacc = 1'b0; ewe = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      a[m_owner] = bus.ctrl_ack_i;
      ea   = bus.port_adr_i[32*m_owner +: 32];
      ed   = bus.port_dat_i[16*m_owner +: 16];
      es   = bus.port_sel_i[2*m_owner +: 2];
      eacc = bus.port_acc_i[m_owner];
      ewe  = bus.port_we_i[m_owner];
    end
    chk("grant", bus.grant_o, g);
    chk("port_ack", bus.port_ack_o, a);
    chk("ctrl_adr", bus.ctrl_adr_o, ea);
    chk("ctrl_dat", bus.ctrl_dat_o, ed);
    chk("ctrl_sel", bus.ctrl_sel_o, es);
    chk("ctrl_acc", bus.ctrl_acc_o, eacc);
    chk("ctrl_we", bus.ctrl_we_o, ewe);
    chk("bc_adr", bus.port_adr_o, bus.ctrl_adr_i);
    chk("bc_dat", bus.port_dat_o, bus.ctrl_dat_i);
  endtask

  task automatic model_step();
    bit found;
    int idx;
    if (rst) begin
      m_owner = -1;
      m_last  = NP - 1;
      m_hold  = 0;
      m_we    = 1'b0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        idx = (m_last + k) % NP;
        if (!found && bus.port_acc_i[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_we    = bus.port_we_i[idx];
          m_hold  = 0;
        end
      end
    end else if (m_hold == 0) begin
      if (!bus.port_acc_i[m_owner]) begin
        if (m_we || HC == 0) begin
          m_last  = m_owner;
          m_owner = -1;
        end else begin
          m_hold = HC;
        end
      end
    end else begin
      if (bus.port_acc_i[m_owner]) begin
        m_hold = 0;
      end else if (m_hold == 1) begin
        m_last  = m_owner;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_port(int p, bit acc, bit we,
                          logic [31:0] a, logic [15:0] d,
                          logic [1:0] s);
    bus.port_acc_i[p]         = acc;
    bus.port_we_i[p]          = we;
    bus.port_adr_i[32*p +: 32] = a;
    bus.port_dat_i[16*p +: 16] = d;
    bus.port_sel_i[2*p +: 2]   = s;
  endtask

  task automatic clear_all();
    bus.port_acc_i = '0;
    bus.port_we_i  = '0;
    bus.port_adr_i = '0;
    bus.port_dat_i = '0;
    bus.port_sel_i = '0;
    bus.ctrl_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int cnt;

  initial begin
    clear_all();
    bus.ctrl_adr_i = 32'h1234_5678;
    bus.ctrl_dat_i = 16'hA5A5;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_acc", bus.ctrl_acc_o, 0);
    chk("rst_adr", bus.ctrl_adr_o, 0);

    // single write from port 1
    set_port(1, 1'b1, 1'b1, 32'h100, 16'hBEEF, 2'b11);
    #1;
    chk("wr_acc_lat", bus.ctrl_acc_o, 0);
    tick();
    chk("wr_acc", bus.ctrl_acc_o, 1);
    chk("wr_adr", bus.ctrl_adr_o, 32'h100);
    chk("wr_dat", bus.ctrl_dat_o, 16'hBEEF);
    chk("wr_sel", bus.ctrl_sel_o, 2'b11);
    chk("wr_we", bus.ctrl_we_o, 1);
    bus.ctrl_ack_i = 1'b1;
    #1;
    chk("wr_ack", bus.port_ack_o, 2'b10);
    bus.port_acc_i[1] = 1'b0;
    #1;
    chk("wr_ack_drop", bus.port_ack_o, 2'b10);
    tick();
    bus.ctrl_ack_i = 1'b0;
    chk("wr_idle", bus.grant_o, 0);
    clear_all();
    tick();

    // simultaneous requests, round robin
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'h10, 16'h1, 2'b01);
    set_port(1, 1'b1, 1'b1, 32'h20, 16'h2, 2'b10);
    tick();
    chk("rr_first", bus.grant_o, 2'b01);
    bus.port_acc_i[0] = 1'b0;
    tick();
    chk("rr_gap", bus.grant_o, 2'b00);
    tick();
    chk("rr_second", bus.grant_o, 2'b10);
    bus.port_acc_i[1] = 1'b0;
    tick();
    bus.port_acc_i = 2'b11;
    tick();
    chk("rr_third", bus.grant_o, 2'b01);
    clear_all();
    tick();
    tick();

    // read hold across burst gap
    do_reset();
    set_port(0, 1'b1, 1'b0, 32'h40, 16'h0, 2'b11);
    set_port(1, 1'b1, 1'b1, 32'h80, 16'h5, 2'b11);
    tick();
    tick();
    tick();
    bus.port_acc_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_gap", bus.grant_o, 2'b01);
    end
    bus.port_acc_i[0] = 1'b1;
    tick();
    chk("hold_regrant", bus.grant_o, 2'b01);
    chk("hold_reacc", bus.ctrl_acc_o, 1);
    bus.port_acc_i[0] = 1'b0;
    cnt = 0;
    while (bus.grant_o == 2'b01 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("hold_len", cnt, HC + 1);
    tick();
    chk("hold_next", bus.grant_o, 2'b10);
    clear_all();
    tick();
    tick();

    // ack while idle is dropped
    do_reset();
    tick();
    bus.ctrl_ack_i = 1'b1;
    #1;
    chk("idle_ack", bus.port_ack_o, 0);
    tick();
    chk("idle_stay", bus.grant_o, 0);
    bus.ctrl_ack_i = 1'b0;

    // reset while port 1 is granted
    set_port(1, 1'b1, 1'b1, 32'hC0, 16'h7, 2'b01);
    tick();
    chk("mid_grant", bus.grant_o, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_grant", bus.grant_o, 0);
    chk("mid_rst_acc", bus.ctrl_acc_o, 0);
    bus.port_acc_i = 2'b11;
    tick();
    chk("mid_rst_win", bus.grant_o, 2'b01);
    clear_all();
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (bus.port_acc_i[p]) begin
          if ($urandom_range(5) == 0) bus.port_acc_i[p] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          bus.port_acc_i[p] = 1'b1;
          bus.port_we_i[p]  = 1'($urandom_range(1));
        end
        bus.port_adr_i[32*p +: 32] = $urandom;
        bus.port_dat_i[16*p +: 16] = 16'($urandom);
        bus.port_sel_i[2*p +: 2]   = 2'($urandom);
      end
      bus.ctrl_ack_i = ($urandom_range(2) == 0);
      bus.ctrl_adr_i = $urandom;
      bus.ctrl_dat_i = 16'($urandom);
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter between N internal SDRAM ports (the 16-bit acc/ack side of each Wishbone port bridge) and the single SDRAM controller command interface. Lives entirely in the SDRAM clock domain. It grants one port at a time and muxes that port's address, data, select and write-enable to the controller. It routes the controller ack back only to the granted port and holds a read owner's grant across the idle gap between its back-to-back burst requests.

## Interface
- NUM_PORTS, 2: number of arbitrated ports (1..8).
- HOLD_CYCLES, 8: cycles a read owner keeps the grant after dropping acc; 0 disables hold.
- sdram_clk  in  1  clock, all logic rising-edge.
- sdram_rst  in  1  reset, synchronous, active-high.
- port_adr_i  in  32*NUM_PORTS  per-port address, port i at [32*i+31:32*i].
- port_dat_i  in  16*NUM_PORTS  per-port write data.
- port_sel_i  in  2*NUM_PORTS  per-port byte selects.
- port_acc_i  in  NUM_PORTS  per-port access request.
- port_we_i  in  NUM_PORTS  per-port write enable.
- port_ack_o  out  NUM_PORTS  per-port ack, only owner bit may be high.
- port_adr_o  out  32  controller current address, broadcast to all ports.
- port_dat_o  out  16  controller read data, broadcast to all ports.
- grant_o  out  NUM_PORTS  one-hot owner, zero when IDLE.
- ctrl_adr_o  out  32  muxed address to controller.
- ctrl_dat_o  out  16  muxed write data.
- ctrl_sel_o  out  2  muxed selects.
- ctrl_acc_o  out  1  muxed access request.
- ctrl_we_o  out  1  muxed write enable.
- ctrl_ack_i  in  1  controller ack.
- ctrl_adr_i  in  32  controller current address.
- ctrl_dat_i  in  16  controller read data.

## Operation
- States: IDLE, GRANT, HOLD. Registers: state, owner index, owner_we (we latched at grant), last index, hold counter (width clog2(HOLD_CYCLES+1)).
- IDLE: if any port_acc_i set, owner <= first requesting index scanning last+1, last+2, … modulo NUM_PORTS; owner_we <= port_we_i[sel]; state -> GRANT. No request: stay.
- GRANT: if port_acc_i[owner] low: owner_we=1 or HOLD_CYCLES=0 -> IDLE, last <= owner; else -> HOLD, counter <= HOLD_CYCLES-1.
- HOLD: port_acc_i[owner] high -> GRANT (same owner, no re-arbitration). Else counter==0 -> IDLE, last <= owner; else counter decrements.
- Mux is combinational from registered owner. ctrl_adr_o/dat_o/sel_o/we_o = owner's inputs whenever state != IDLE, else all zero. ctrl_acc_o = (state != IDLE) & port_acc_i[owner]. Ports drive adr/dat/sel combinationally from ack, so no registering on that path.
- port_ack_o[i] = ctrl_ack_i & (state != IDLE) & (owner == i). In IDLE, ctrl_ack_i is dropped.
- port_adr_o = ctrl_adr_i, port_dat_o = ctrl_dat_i: wires, ungated. Ports qualify with their own ack/state.
- grant_o = one-hot(owner) when state != IDLE, else 0.
- Non-owner requests are ignored until the owner releases. No preemption.

## Timing
- Reset values: state IDLE, owner 0, owner_we 0, last NUM_PORTS-1 (port 0 wins first), counter 0. All outputs 0 except broadcast wires.
- Request to ctrl_acc_o: 1 cycle. port_acc_i rises in cycle n, ctrl_acc_o is high in cycle n+1.
- Release: owner drops acc in cycle n. The next arbitration IDLE cycle is n+1 for a write. For a read it is n+1+HOLD_CYCLES; a new owner's acc is visible one cycle after that.
- HOLD with reassertion on the last counter cycle (counter==0): reassertion wins, go to GRANT.
- Owner drops acc in the same cycle ctrl_ack_i arrives: ack still forwarded, then the release path is taken.
- Reset mid-grant: ctrl_acc_o low the next cycle. The controller must be reset together with the arbiter.
- NUM_PORTS=1: degenerate pass-through with the 1-cycle grant latency.

## Test plan
- Single write from port 1 (acc+we, adr 0x100, dat 0xBEEF, sel 2'b11) -> ctrl_acc_o high one cycle later with those values; on ctrl_ack_i, port_ack_o=2'b10; IDLE the cycle after acc drops.
- Port 0 and 1 request together out of reset -> port 0 granted first. After release, port 1 is granted. A later simultaneous request grants port 0 again (round robin).
- Port 0 read, acc drops 3 cycles, then reasserts, HOLD_CYCLES=8; port 1 requesting throughout -> grant_o stays 2'b01 across the gap; port 1 granted only after final release plus 8 cycles.
- Read owner never reasserts -> exactly HOLD_CYCLES cycles in HOLD, then IDLE; ctrl_acc_o low throughout HOLD.
- ctrl_ack_i pulse while IDLE -> port_ack_o stays 0; state stays IDLE.
- sdram_rst asserted during GRANT with port 1 active -> next cycle grant_o=0, ctrl_acc_o=0; after release port 0 wins if both request.
